// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified IF/MEM memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Byte address -> word address shift for a 32-bit word memory.
    localparam int ADDR_LSB = 2;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Request/response and memory-port bundle between the core stages, the arbiter and the memory.
interface unified_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = be_width(DATA_W);

    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [BE_W-1:0]       d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [BE_W-1:0]       mem_be;
    logic [ADDR_W-3:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/unified_mem_arbiter_rsp_steer.sv
// Routes synchronous-read memory data back to the stage that issued the read and holds it
// per stage; rdata is bypassed from memory in the response cycle and registered afterwards.
module rsp_steer
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_issue,
    input  owner_t            i_rd_owner,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata
);

    logic              r_rsp_pending;
    owner_t            r_rsp_owner;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_if_rvalid;
    logic              w_d_rvalid;

    assign w_if_rvalid = r_rsp_pending && (r_rsp_owner == OWN_IF);
    assign w_d_rvalid  = r_rsp_pending && (r_rsp_owner == OWN_D);

    // Reset drops any in-flight read so no response is produced after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_pending <= 1'b0;
            r_rsp_owner   <= OWN_IF;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
        end else begin
            r_rsp_pending <= i_rd_issue;
            if (i_rd_issue) begin
                r_rsp_owner <= i_rd_owner;
            end
            if (w_if_rvalid) begin
                r_if_rdata <= i_mem_rdata;
            end
            if (w_d_rvalid) begin
                r_d_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_if_rvalid = w_if_rvalid;
    assign o_d_rvalid  = w_d_rvalid;
    assign o_if_rdata  = w_if_rvalid ? i_mem_rdata : r_if_rdata;
    assign o_d_rdata   = w_d_rvalid  ? i_mem_rdata : r_d_rdata;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Phase-driven arbiter sharing one single-port memory between IF fetch and MEM load/store.
// Define PHASE_STEAL_EN to let a lone requester use the other stage's idle phase.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_tock,
    unified_mem_arbiter_if.slave bus
);

    localparam int BE_W = be_width(DATA_W);

    logic            w_if_gnt;
    logic            w_d_gnt;
    logic            w_d_write;
    logic            w_rd_issue;
    owner_t          w_rd_owner;
    logic [BE_W-1:0] w_be;
    logic            w_unused_addr_lsbs;

`ifdef PHASE_STEAL_EN
    assign w_if_gnt = bus.if_req & (tick_tock | ~bus.d_req);
    assign w_d_gnt  = bus.d_req  & (~tick_tock | ~bus.if_req);
`else
    assign w_if_gnt = bus.if_req & tick_tock;
    assign w_d_gnt  = bus.d_req  & ~tick_tock;
`endif

    assign w_d_write = w_d_gnt & bus.d_we;

    // Only a granted MEM write narrows the byte lanes; fetches and loads take the full word.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
            assign w_be[gi] = ~w_d_write | bus.d_be[gi];
        end
    endgenerate

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_en    = w_if_gnt | w_d_gnt;
    assign bus.mem_we    = w_d_write;
    assign bus.mem_be    = w_be;
    assign bus.mem_addr  = w_d_gnt ? bus.d_addr[ADDR_W-1:ADDR_LSB]
                                   : bus.if_addr[ADDR_W-1:ADDR_LSB];
    assign bus.mem_wdata = bus.d_wdata;

    assign w_rd_issue = w_if_gnt | (w_d_gnt & ~bus.d_we);
    assign w_rd_owner = w_d_gnt ? OWN_D : OWN_IF;

    assign w_unused_addr_lsbs = ^{bus.if_addr[ADDR_LSB-1:0], bus.d_addr[ADDR_LSB-1:0]};

    rsp_steer #(
        .DATA_W (DATA_W)
    ) u_rsp_steer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_issue  (w_rd_issue),
        .i_rd_owner  (w_rd_owner),
        .i_mem_rdata (bus.mem_rdata),
        .o_if_rvalid (bus.if_rvalid),
        .o_if_rdata  (bus.if_rdata),
        .o_d_rvalid  (bus.d_rvalid),
        .o_d_rdata   (bus.d_rdata)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a word-level model.
// Honours PHASE_STEAL_EN the same way the design does.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef PHASE_STEAL_EN
    localparam int STEAL_EXP = 8;
`else
    localparam int STEAL_EXP = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tick  = 1'b0;

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_tock (tick),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Physical single-port memory with one-cycle synchronous read.
    logic [31:0] sim_mem [64];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be[b]) sim_mem[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end else begin
                bus.mem_rdata <= sim_mem[bus.mem_addr[5:0]];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    bit          exp_if_rv, exp_d_rv;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          g_if, g_d;
    logic        obs_if_gnt;
    int          n_if_grants, n_d_grants;
    int          n_checks, n_errors;
    bit          rand_tick;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        exp_if_rv    = 0;
        exp_d_rv     = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
    endtask

    // One clock: check everything at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit eif, ed, nif, nd;
        logic [31:0] nifd, ndd;
        @(negedge clk);
        eif = tick && bus.if_req;
        ed  = !tick && bus.d_req;
`ifdef PHASE_STEAL_EN
        if (!eif && !ed) begin
            if (bus.if_req) eif = 1;
            else if (bus.d_req) ed = 1;
        end
`endif
        check("if_gnt", bus.if_gnt, eif);
        check("d_gnt", bus.d_gnt, ed);
        check("mem_en", bus.mem_en, eif || ed);
        check("mem_we", bus.mem_we, ed && bus.d_we);
        if (eif) begin
            check("mem_addr_if", bus.mem_addr, bus.if_addr >> 2);
            check("mem_be_if", bus.mem_be, 4'hF);
        end
        if (ed) begin
            check("mem_addr_d", bus.mem_addr, bus.d_addr >> 2);
            check("mem_be_d", bus.mem_be, bus.d_we ? bus.d_be : 4'hF);
            if (bus.d_we) check("mem_wdata", bus.mem_wdata, bus.d_wdata);
        end
        check("if_rvalid", bus.if_rvalid, exp_if_rv);
        check("d_rvalid", bus.d_rvalid, exp_d_rv);
        check("if_rdata", bus.if_rdata, exp_if_rdata);
        check("d_rdata", bus.d_rdata, exp_d_rdata);

        nif  = eif;
        nd   = ed && !bus.d_we;
        nifd = exp_if_rdata;
        ndd  = exp_d_rdata;
        if (eif) nifd = ref_mem[bus.if_addr[7:2]];
        if (nd)  ndd  = ref_mem[bus.d_addr[7:2]];
        if (ed && bus.d_we)
            ref_mem[bus.d_addr[7:2]] = be_merge(ref_mem[bus.d_addr[7:2]], bus.d_wdata, bus.d_be);
        g_if = eif;
        g_d  = ed;
        obs_if_gnt = bus.if_gnt;
        if (eif) n_if_grants++;
        if (ed)  n_d_grants++;
        @(posedge clk);
        exp_if_rv    = nif;
        exp_d_rv     = nd;
        exp_if_rdata = nifd;
        exp_d_rdata  = ndd;
        #1;
        tick = rand_tick ? 1'($urandom_range(0, 1)) : ~tick;
    endtask

    task automatic d_access(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                            input logic [3:0] be);
        bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd; bus.d_be = be;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (g_d) break;
        end
        if (!g_d) check("d_grant_timeout", bus.d_gnt, 1);
        bus.d_req = 0;
    endtask

    task automatic if_access(input logic [31:0] addr);
        bus.if_req = 1; bus.if_addr = addr;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (g_if) break;
        end
        if (!g_if) check("if_grant_timeout", bus.if_gnt, 1);
        bus.if_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int waitc;
        n_checks = 0; n_errors = 0; rand_tick = 0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_if_rvalid", bus.if_rvalid, 0);
        check("reset_d_rvalid", bus.d_rvalid, 0);
        check("reset_if_rdata", bus.if_rdata, 0);
        check("reset_d_rdata", bus.d_rdata, 0);
        rst_n = 1;

        for (int i = 0; i < 64; i++) d_access(32'(i * 4), 1, $urandom, 4'hF);
        cycle();

        // Alternation with both stages holding requests
        d_access(32'h10, 1, 32'hDEADBEEF, 4'hF);
        d_access(32'h40, 1, 32'hCAFEF00D, 4'hF);
        bus.if_req = 1; bus.if_addr = 32'h10;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
        n_if_grants = 0; n_d_grants = 0;
        repeat (4) cycle();
        bus.if_req = 0; bus.d_req = 0;
        check("alt_if_grants", n_if_grants, 2);
        check("alt_d_grants", n_d_grants, 2);
        cycle();
        check("alt_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        check("alt_d_rdata", bus.d_rdata, 32'hCAFEF00D);

        // Reset while an IF read is in flight
        if_access(32'h40);
        rst_n = 0;
        model_reset();
        #2;
        check("rst_inflight_if_rvalid", bus.if_rvalid, 0);
        check("rst_inflight_if_rdata", bus.if_rdata, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        cycle();
        cycle();
        check("post_rst_if_rvalid", bus.if_rvalid, 0);

        // Byte-enable writes
        d_access(32'h20, 1, 32'h11223344, 4'hF);
        d_access(32'h20, 1, 32'hAABBCCDD, 4'b0011);
        check("bw_no_rvalid", bus.d_rvalid, 0);
        d_access(32'h20, 0, 32'h0, 4'h0);
        check("bw_rvalid", bus.d_rvalid, 1);
        check("bw_merge", bus.d_rdata, 32'h1122CCDD);
        d_access(32'h21, 1, 32'hFFFFFFFF, 4'b0000);
        check("be0_no_rvalid", bus.d_rvalid, 0);
        d_access(32'h20, 0, 32'h0, 4'h0);
        check("be0_unchanged", bus.d_rdata, 32'h1122CCDD);
        cycle();

        // MEM request raised in IF's phase waits exactly one cycle
        if (tick == 1'b0) cycle();
        bus.if_req = 1; bus.if_addr = 32'h10;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
        waitc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (g_if) bus.if_addr = 32'h44;
            if (g_d) break;
            waitc++;
        end
        check("wp_wait_cycles", waitc, 1);
        check("wp_if_gnt_low", obs_if_gnt, 0);
        bus.d_req = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (g_if) break;
        end
        bus.if_req = 0;
        cycle();

        // IF read data holds across MEM responses and idle cycles
        if_access(32'h10);
        check("hold_first", bus.if_rdata, 32'hDEADBEEF);
        d_access(32'h40, 0, 32'h0, 4'h0);
        repeat (3) cycle();
        check("hold_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        check("hold_d_rdata", bus.d_rdata, 32'hCAFEF00D);

        // Lone IF requester for 8 cycles
        bus.if_req = 1; bus.if_addr = 32'h0;
        n_if_grants = 0;
        repeat (8) begin
            cycle();
            if (g_if) bus.if_addr = 32'($urandom_range(0, 255));
        end
        bus.if_req = 0;
        check("steal_grants", n_if_grants, STEAL_EXP);
        cycle();

        // Randomized traffic
        rand_tick = 1;
        for (int i = 0; i < 400; i++) begin
            if (!bus.if_req && $urandom_range(0, 1) == 1) begin
                bus.if_req = 1; bus.if_addr = 32'($urandom_range(0, 255));
            end
            if (!bus.d_req && $urandom_range(0, 1) == 1) begin
                bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1));
                bus.d_be = 4'($urandom); bus.d_addr = 32'($urandom_range(0, 255));
                bus.d_wdata = $urandom;
            end
            cycle();
            if (g_if) bus.if_req = 0;
            if (g_d)  bus.d_req = 0;
        end
        bus.if_req = 0; bus.d_req = 0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
